// File: rtl/tensor_hmma_sequencer.sv
// rtl/tensor_hmma_sequencer.sv - round-robin HMMA macro issue sequencer with step credit throttling
module tensor_hmma_sequencer #(
  parameter int NUM_REQ     = 4,
  parameter int TAGW        = 16,
  parameter int MAX_CREDITS = 4,
  localparam int SELW       = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*TAGW-1:0] req_tag,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic [1:0]              dp_step,
  output logic                    dp_substep,
  output logic [SELW-1:0]         dp_sel,
  output logic [TAGW-1:0]         dp_tag,
  input  logic                    res_retire,
  output logic                    idle,
  output logic                    credit_err
);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_ISSUE = 1'b1;
  localparam logic [CW-1:0]   CRED_MAX = CW'(MAX_CREDITS);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NUM_REQ - 1);

  logic [0:0]      state;
  logic [SELW-1:0] rr_ptr;
  logic [2:0]      beat;
  logic [CW-1:0]   credits;

  logic            grant_found;
  logic [SELW-1:0] grant_sel;
  logic            fire;
  logic            consume;
  logic            last_fire;

  // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets high to low and let later hits override.
  always_comb begin
    int              idx;
    logic [SELW-1:0] idx_s;
    idx         = 0;
    idx_s       = '0;
    grant_found = 1'b0;
    grant_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_s = SELW'(idx);
      if (req_valid[idx_s]) begin
        grant_found = 1'b1;
        grant_sel   = idx_s;
      end
    end
  end

  assign fire      = dp_valid && dp_ready;
  assign consume   = fire && beat[0];
  assign last_fire = fire && (beat == 3'd7);

  // Beat outputs come straight from the beat counter; a credit gates the buffered half and the compute half rides on it.
  always_comb begin
    dp_valid   = (state == ST_ISSUE) && (credits != '0);
    dp_step    = beat[2:1];
    dp_substep = beat[0];
    idle       = (state == ST_IDLE) && (credits == CRED_MAX);
    req_ready  = '0;
    if (last_fire) req_ready[dp_sel] = 1'b1;
  end

  // Grant/issue FSM: lock one slot, walk its 8 beats, then advance the round-robin pointer past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      beat   <= '0;
      dp_sel <= '0;
      dp_tag <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            state  <= ST_ISSUE;
            dp_sel <= grant_sel;
            dp_tag <= req_tag[grant_sel*TAGW +: TAGW];
            beat   <= '0;
          end
        end
        ST_ISSUE: begin
          if (fire) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              state  <= ST_IDLE;
              rr_ptr <= (dp_sel == SEL_LAST) ? '0 : dp_sel + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credit counter: retire returns one, a compute-half fire takes one; a return into a full pool is flagged and dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({res_retire, consume})
        2'b10: begin
          if (credits == CRED_MAX) credit_err <= 1'b1;
          else                     credits    <= credits + 1'b1;
        end
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tensor_hmma_sequencer.md
# tensor_hmma_sequencer

- Issue-side controller for the warp tensor-core datapath.
- Accepts one HMMA macro request per issue slot and arbitrates round-robin among `NUM_REQ` slots.
- Locks the grant and drives the granted macro as 8 back-to-back beats (4 steps × 2 substeps), which the octets require.
- Throttles issue with a credit counter on results still in flight; sits between dispatch and the tensor-core operand/beat interface.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting issue slots (≥2)
- `TAGW`, 16, request tag width (packed uuid/wid/rd, opaque to block)
- `MAX_CREDITS`, 4, max steps issued but not yet retired by the datapath (≥1)

Ports (`SELW = $clog2(NUM_REQ)`, `CW = $clog2(MAX_CREDITS+1)`):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  slot i holds a pending macro
- `req_tag`  in  NUM_REQ×TAGW  per-slot tag
- `req_ready`  out  NUM_REQ  one-cycle pulse: slot's macro fully issued
- `dp_valid`  out  1  beat valid to datapath
- `dp_ready`  in  1  datapath accepts beat
- `dp_step`  out  2  HMMA step 0..3
- `dp_substep`  out  1  0 = buffered half, 1 = compute half
- `dp_sel`  out  SELW  granted slot (operand mux select)
- `dp_tag`  out  TAGW  tag captured at grant
- `res_retire`  in  1  one step's results fully committed (credit return)
- `idle`  out  1  no macro active and all credits home
- `credit_err`  out  1  sticky: retire seen with credits full

## Operation
- State `IDLE`:
  - If any `req_valid`, pick the first valid slot at or after `rr_ptr` (wrapping).
  - Register `dp_sel`, capture `dp_tag` from that slot, set `beat=0`, go to `ISSUE`.
  - If no `req_valid`, stay in `IDLE`.
- State `ISSUE`:
  - `dp_valid = (credits != 0)`, `dp_step = beat[2:1]`, `dp_substep = beat[0]`.
  - On a fire (`dp_valid && dp_ready`): `beat` increments.
  - A fire with `dp_substep==1` consumes one credit.
  - On a fire of `beat==7`: `req_ready[dp_sel]=1` in that same cycle, `rr_ptr <= (dp_sel+1) mod NUM_REQ`, go to `IDLE`.
- Credits:
  - Reset to `MAX_CREDITS`.
  - `res_retire` adds 1; a substep-1 fire subtracts 1; both in the same cycle leaves the count unchanged.
  - `res_retire` with credits at `MAX_CREDITS` and no consume: count unchanged, `credit_err <= 1` (sticky until reset).
  - A credit is checked on substep 0 and only consumed on substep 1, so a step's two beats are never split by credit starvation.
- Grant lock:
  - Slots other than `dp_sel` are ignored until the macro completes.
  - `req_tag` and `req_valid` of the granted slot are not re-sampled after grant.
  - `req_valid` dropping mid-macro is a protocol violation; the sequence still completes.
- `idle = (state==IDLE) && (credits==MAX_CREDITS)`.
- Non-granted `req_ready` bits are always 0.

## Timing
- Reset values:
  - `state=IDLE`, `rr_ptr=0`, `beat=0`, `credits=MAX_CREDITS`.
  - `dp_valid=0`, `dp_sel=0`, `dp_tag=0`, `dp_step=0`, `dp_substep=0`.
  - `req_ready=0`, `credit_err=0`, `idle=1`.
- Reset asserted mid-macro: all state is cleared immediately and no `req_ready` pulse is issued. The datapath must be reset alongside.
- Arbitration latency: `req_valid` high in cycle 0 → `dp_valid` in cycle 1 (credits available).
- Uncontended macro with `dp_ready=1` and ample credits: beats in cycles 1..8, `req_ready` in cycle 8.
- Turnaround: the next grant is made in cycle 9 and its first beat is in cycle 10 (1 bubble).
- Beat outputs hold stable while `dp_valid && !dp_ready`.
- `dp_valid` may drop only before a substep-0 beat, and only when credits are 0.
- `res_retire` is accepted in any state, including `IDLE`.

## Test plan
- **Single macro:** slot 2 valid, tag `0x00AB`, `dp_ready=1`, periodic retires.
  - `dp_sel=2`, `dp_tag=0x00AB`.
  - `(step,substep)` = (0,0),(0,1),(1,0)…(3,1) in cycles 1–8.
  - `req_ready=4'b0100` in cycle 8 only.
- **Round-robin fairness:** slots 0, 1, 3 held valid continuously.
  - Grants in order 0,1,3,0,1,3, each exactly 8 beats, never interleaved.
  - `rr_ptr` after slot 3 wraps to 0.
- **Credit stall:** `MAX_CREDITS=1`, no retire.
  - Beats (0,0),(0,1) issue, then `dp_valid=0` with `credits=0`.
  - A `res_retire` pulse in cycle 6 → beat (1,0) in cycle 7.
  - The compute half of a step never issues without its buffered half.
- **Backpressure:** `dp_ready` toggles 1,0,0,1,…
  - Outputs stable during stalls, beat order unchanged.
  - `req_ready` pulses only on the fire of the 8th beat.
- **Simultaneous consume/retire and overflow:**
  - `res_retire` in the same cycle as a substep-1 fire → credits unchanged.
  - An extra retire with credits full → `credit_err=1`, count stays `MAX_CREDITS`.
- **Async reset mid-macro:** reset at beat 5.
  - Outputs go to reset values with no clock edge, no `req_ready`, `idle=1`.
  - After release, a valid slot 1 is granted (`rr_ptr=0` scan).
